mc_controller: RTL
==================

Name: mc_controller

Overview:
- Multicycle control unit directly upstream of the 32-bit ALU.
- Sequences each instruction through a Moore FSM and drives the datapath muxes and write enables.
- Produces the 3-bit ALU function select from a 2-bit ALU op and the instruction funct field.
- Consumes the ALU `zero` flag to resolve beq.

Parameters:
- None. Encodings are fixed in the shared package.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- stall  input  1  memory not ready; freezes FSM, suppresses writes
- op  input  6  instruction opcode from the instruction register
- funct  input  6  instruction funct field from the instruction register
- zero  input  1  ALU zero flag
- pcen  output  1  PC register enable = pcwrite | (branch & zero)
- irwrite  output  1  instruction register enable
- memwrite  output  1  data memory write
- regwrite  output  1  register file write
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  write-back select: 0 = ALUOut, 1 = Data
- regdst  output  1  destination register: 0 = rt, 1 = rd
- alusrca  output  1  ALU operand a: 0 = PC, 1 = register A
- alusrcb  output  2  ALU operand b: 00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU function select f
- illegal  output  1  high in DECODE when op is unsupported

Behaviour:
- State register:
  - async reset to FETCH.
  - otherwise updates on the rising edge of clk when stall = 0.
  - holds when stall = 1.
- All outputs are combinational from state (plus funct for alucontrol, zero for pcen). Unlisted outputs are 0.
- Per-state outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next by op:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEXEC
    - 000010 j -> JUMP
    - other -> FETCH, with illegal=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR: iord=1, memwrite=1. Next: FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- Cycles per instruction, FETCH to next FETCH with no stall: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- ALU decode (combinational):
  - aluop 00 -> 010 (add); 01 -> 110 (sub).
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010.
  - aluop 11 -> 010.
- Gating: while reset = 1 or stall = 1, the following are forced 0:
  - pcen, irwrite, memwrite, regwrite
  - Mux selects and alucontrol still follow the state.
- Reset mid-instruction:
  - aborts immediately with no further writes.
  - first cycle after release is FETCH.
- Stall + zero: pcen stays 0 in BRANCH while stalled. It is re-evaluated with the current zero when stall drops.
- op/funct are sampled only in DECODE, MEMADR and EXECUTE. They must be stable from DECODE to instruction end; the controller does not latch them.
- Reset values: state FETCH; pcen = irwrite = memwrite = regwrite = 0; other outputs equal FETCH values.

Decomposition:
- Package mc_ctrl_pkg:
  - state_t enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  - aluop_t (2 bit)
  - opcode constants: OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - ALU function constants matching the ALU encoding
- Sub-module alu_dec: combinational aluop + funct -> alucontrol.
- The FSM and output decode stay in mc_controller.

Test Plan:
- Reset held 3 cycles with op=100011, then released:
  - write enables 0 during reset.
  - after release, states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - regwrite=1 and memtoreg=1 only in cycle 5; back to FETCH in cycle 6.
- R-type sub (op=000000, funct=100010): alucontrol=110 in EXECUTE; ALUWB has regdst=1, regwrite=1; 4 cycles total.
- beq:
  - zero=1: BRANCH pcen=1, pcsrc=01, alucontrol=110.
  - zero=0: pcen=0.
  - 3 cycles each.
- sw with stall=1 for 2 cycles in MEMWR: memwrite=0 while stalled; memwrite=1 on the first unstalled cycle; then FETCH.
- op=111111: illegal=1 in DECODE; next state FETCH; no memwrite/regwrite asserted.
- Reset asserted asynchronously mid-ALUWB (between edges): regwrite drops immediately; state is FETCH on release; j then completes in 3 cycles with pcsrc=10.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU op classes,
// instruction opcode/funct fields and the ALU function select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the controller's ALU op class and the instruction funct
// field onto the 3-bit ALU function select.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  aluop_t      aluop_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alucontrol_o
);

  // funct only matters for R-type; unknown functs fall back to add
  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD:   alucontrol_o = ALU_ADD;
          F_SUB:   alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLT:   alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control unit: sequences each instruction through the FSM and
// drives datapath mux selects and write enables; writes are blocked in reset/stall.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t state_q, state_d;
  aluop_t aluop_s;
  logic   pcwrite_s, branch_s, irwrite_s, memwrite_s, regwrite_s, wr_block_s;

  // Next-state selection; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // State register; a stall freezes the sequence in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else if (!stall) begin
      state_q <= state_d;
    end else begin
      state_q <= state_q;
    end
  end

  // Moore output decode, ungated write enables
  always_comb begin
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop_s    = ALUOP_ADD;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !is_legal_op(op);
      end
      MEMADR, ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop_s = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop_s  = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
      end
      ADDIWB: regwrite_s = 1'b1;
      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: illegal = 1'b0;
    endcase
  end

  // Reset acts combinationally here so an asynchronous abort drops writes at once
  assign wr_block_s = reset | stall;
  assign pcen       = !wr_block_s & (pcwrite_s | (branch_s & zero));
  assign irwrite    = !wr_block_s & irwrite_s;
  assign memwrite   = !wr_block_s & memwrite_s;
  assign regwrite   = !wr_block_s & regwrite_s;

  alu_dec u_alu_dec (
    .aluop_i      (aluop_s),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule
